// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, redirect, fetch-busy and data-memory
// wait handling, plus saturating stall/redirect performance counters.
module pipe_hazard_ctrl #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic              ex_valid,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_rf_wen,
    input  logic              ex_is_load,
    input  logic              ex_redirect,
    input  logic              if_busy,
    input  logic              mem_req,
    input  logic              mem_ready,
    output logic              pc_ena,
    output logic              ifid_ena,
    output logic              idex_ena,
    output logic              exmem_ena,
    output logic              memwb_ena,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic              memwb_flush,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef enum logic [1:0] {StRun, StMemWait, StDrain} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    logic mem_stall;
    logic redirect;
    logic load_use;
    logic redirect_taken;

    assign mem_stall = ((state_q == StRun) && mem_req && !mem_ready) ||
                       ((state_q == StMemWait) && !mem_ready);
    assign redirect  = ex_valid && ex_redirect;
    assign load_use  = ex_valid && ex_is_load && ex_rf_wen && (ex_rd != '0) && id_valid &&
                       ((id_rs1_used && (id_rs1 == ex_rd)) || (id_rs2_used && (id_rs2 == ex_rd)));

    always_comb begin
        state_d        = state_q;
        pc_ena         = 1'b0;
        ifid_ena       = 1'b0;
        idex_ena       = 1'b0;
        exmem_ena      = 1'b0;
        memwb_ena      = 1'b0;
        ifid_flush     = 1'b0;
        idex_flush     = 1'b0;
        memwb_flush    = 1'b0;
        redirect_taken = 1'b0;
        if (rst) begin
            state_d = StRun;
        end else if (mem_stall) begin
            // Upstream frozen; WB receives a bubble while the access is outstanding.
            memwb_ena   = 1'b1;
            memwb_flush = 1'b1;
            state_d     = StMemWait;
        end else if (redirect) begin
            pc_ena         = 1'b1;
            ifid_ena       = 1'b1;
            idex_ena       = 1'b1;
            exmem_ena      = 1'b1;
            memwb_ena      = 1'b1;
            ifid_flush     = 1'b1;
            idex_flush     = 1'b1;
            redirect_taken = 1'b1;
            state_d        = if_busy ? StDrain : StRun;
        end else if (state_q == StDrain) begin
            // Wrong-path fetch still in flight: discard whatever arrives, hold PC on target.
            ifid_ena   = 1'b1;
            idex_ena   = 1'b1;
            exmem_ena  = 1'b1;
            memwb_ena  = 1'b1;
            ifid_flush = 1'b1;
            state_d    = if_busy ? StDrain : StRun;
        end else if (load_use) begin
            idex_ena   = 1'b1;
            exmem_ena  = 1'b1;
            memwb_ena  = 1'b1;
            idex_flush = 1'b1;
            state_d    = StRun;
        end else if (if_busy) begin
            ifid_ena   = 1'b1;
            idex_ena   = 1'b1;
            exmem_ena  = 1'b1;
            memwb_ena  = 1'b1;
            ifid_flush = 1'b1;
            state_d    = StRun;
        end else begin
            pc_ena    = 1'b1;
            ifid_ena  = 1'b1;
            idex_ena  = 1'b1;
            exmem_ena = 1'b1;
            memwb_ena = 1'b1;
            state_d   = StRun;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StRun;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (!pc_ena && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (redirect_taken && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed per-cycle vectors push expected controls and
// counters; a negedge monitor pops and compares.
module tb_pipe_hazard_ctrl;

    localparam int unsigned REG_AW  = 5;
    localparam int unsigned CNT_W   = 4;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    // Expected control order: {pc, ifid, idex, exmem, memwb, ifid_fl, idex_fl, memwb_fl}
    localparam logic [7:0] E_RST   = 8'b00000_000;
    localparam logic [7:0] E_ALL   = 8'b11111_000;
    localparam logic [7:0] E_MEM   = 8'b00001_001;
    localparam logic [7:0] E_REDIR = 8'b11111_110;
    localparam logic [7:0] E_DRAIN = 8'b01111_100;
    localparam logic [7:0] E_BUSY  = 8'b01111_100;
    localparam logic [7:0] E_LU    = 8'b00111_010;

    typedef struct packed {
        logic [7:0] ctrl;
        int         st;
        int         fl;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              id_valid, id_rs1_used, id_rs2_used;
    logic [REG_AW-1:0] id_rs1, id_rs2, ex_rd;
    logic              ex_valid, ex_rf_wen, ex_is_load, ex_redirect;
    logic              if_busy, mem_req, mem_ready;
    logic              pc_ena, ifid_ena, idex_ena, exmem_ena, memwb_ena;
    logic              ifid_flush, idex_flush, memwb_flush;
    logic [CNT_W-1:0]  stall_cnt, flush_cnt;

    exp_t q[$];
    int   exp_st = 0;
    int   exp_fl = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_rf_wen(ex_rf_wen), .ex_is_load(ex_is_load),
        .ex_redirect(ex_redirect), .if_busy(if_busy), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_ena(pc_ena), .ifid_ena(ifid_ena), .idex_ena(idex_ena), .exmem_ena(exmem_ena),
        .memwb_ena(memwb_ena), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .memwb_flush(memwb_flush), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    task automatic clear_in();
        rst = 1'b0;
        id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
        ex_valid = 1'b0; ex_rd = '0; ex_rf_wen = 1'b0; ex_is_load = 1'b0; ex_redirect = 1'b0;
        if_busy = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic load_hazard(input logic [REG_AW-1:0] rd, input logic [REG_AW-1:0] rs1,
                               input logic [REG_AW-1:0] rs2, input logic u1, input logic u2);
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_rf_wen = 1'b1; ex_rd = rd;
        id_valid = 1'b1; id_rs1 = rs1; id_rs2 = rs2; id_rs1_used = u1; id_rs2_used = u2;
    endtask

    // Push the expectation for the current inputs, then advance one clock and update the model.
    task automatic tick(input logic [7:0] ctrl);
        exp_t e;
        logic r;
        e.ctrl = ctrl;
        e.st   = exp_st;
        e.fl   = exp_fl;
        r      = rst;
        q.push_back(e);
        @(posedge clk);
        #1;
        if (r) begin
            exp_st = 0;
            exp_fl = 0;
        end else begin
            if (!ctrl[7] && exp_st < CNT_MAX) exp_st++;
            if (ctrl[7] && ctrl[1] && exp_fl < CNT_MAX) exp_fl++;
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        logic [7:0] act;
        if (q.size() > 0) begin
            e   = q.pop_front();
            act = {pc_ena, ifid_ena, idex_ena, exmem_ena, memwb_ena,
                   ifid_flush, idex_flush, memwb_flush};
            checks += 3;
            if (act !== e.ctrl) begin
                errors++;
                $display("FAIL ctrl t=%0t got %b want %b", $time, act, e.ctrl);
            end
            if (stall_cnt !== CNT_W'(e.st)) begin
                errors++;
                $display("FAIL stall_cnt t=%0t got %0d want %0d", $time, stall_cnt, e.st);
            end
            if (flush_cnt !== CNT_W'(e.fl)) begin
                errors++;
                $display("FAIL flush_cnt t=%0t got %0d want %0d", $time, flush_cnt, e.fl);
            end
        end
    end

    initial begin
        clear_in();
        rst = 1'b1;
        @(posedge clk);
        #1;
        // Reset: outputs all low even with hazards present
        clear_in(); rst = 1'b1; mem_req = 1'b1; if_busy = 1'b1; tick(E_RST);
        clear_in(); rst = 1'b1; tick(E_RST);
        clear_in(); tick(E_ALL);
        // Load-use on rs1: exactly one bubble
        clear_in(); load_hazard(5, 5, 0, 1'b1, 1'b0); tick(E_LU);
        clear_in(); tick(E_ALL);
        // No hazard: rd=0, rs1 unused, not a regfile write
        clear_in(); load_hazard(0, 0, 0, 1'b1, 1'b1); tick(E_ALL);
        clear_in(); load_hazard(5, 5, 5, 1'b0, 1'b0); tick(E_ALL);
        clear_in(); load_hazard(5, 5, 0, 1'b1, 1'b0); ex_rf_wen = 1'b0; tick(E_ALL);
        clear_in(); load_hazard(7, 1, 7, 1'b1, 1'b0); tick(E_ALL);
        // Load-use on rs2
        clear_in(); load_hazard(7, 1, 7, 1'b1, 1'b1); tick(E_LU);
        // Load-use beats fetch busy
        clear_in(); load_hazard(3, 3, 0, 1'b1, 1'b0); if_busy = 1'b1; tick(E_LU);
        clear_in(); if_busy = 1'b1; tick(E_BUSY);
        for (int i = 0; i < 5; i++) begin
            clear_in(); if_busy = 1'b1; tick(E_BUSY);
        end
        // Memory wait: 3 frozen cycles, MEM_WAIT holds without mem_req
        clear_in(); mem_req = 1'b1; tick(E_MEM);
        clear_in(); tick(E_MEM);
        clear_in(); tick(E_MEM);
        clear_in(); mem_ready = 1'b1; tick(E_ALL);
        clear_in(); tick(E_ALL);
        // Redirect with wrong-path fetch outstanding, then drain
        clear_in(); ex_valid = 1'b1; ex_redirect = 1'b1; if_busy = 1'b1; tick(E_REDIR);
        clear_in(); if_busy = 1'b1; tick(E_DRAIN);
        clear_in(); if_busy = 1'b1; tick(E_DRAIN);
        clear_in(); tick(E_DRAIN);
        clear_in(); tick(E_ALL);
        // Redirect overrides load-use
        clear_in(); load_hazard(4, 4, 0, 1'b1, 1'b0); ex_redirect = 1'b1; tick(E_REDIR);
        clear_in(); tick(E_ALL);
        // Redirect deferred by memory stall, applied once on completion
        clear_in(); mem_req = 1'b1; ex_valid = 1'b1; ex_redirect = 1'b1; tick(E_MEM);
        clear_in(); mem_req = 1'b1; ex_valid = 1'b1; ex_redirect = 1'b1; tick(E_MEM);
        clear_in(); mem_ready = 1'b1; ex_valid = 1'b1; ex_redirect = 1'b1; tick(E_REDIR);
        clear_in(); tick(E_ALL);
        // Reset while in MEM_WAIT: counters clear, RUN afterwards
        clear_in(); mem_req = 1'b1; tick(E_MEM);
        clear_in(); rst = 1'b1; tick(E_RST);
        clear_in(); tick(E_ALL);
        clear_in(); tick(E_ALL);
        @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain_queue left %0d want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
